// File: rtl/nv_nvdla_sdp_core_y_dmaunpack_rx.sv
// Gathers RATIO narrow beats (fewer on inp_last) into one wide word plus segment mask; word valid the cycle after its closing beat.
// Backpressure: inp_prdy = !out_pvld | out_prdy. Build option SDP_Y_DMAUNPACK_ZERO_FILL_EN zeroes unfilled segments of a partial word.
module nv_nvdla_sdp_core_y_dmaunpack_rx #(
  parameter int IN_W  = 64,
  parameter int RATIO = 4
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  inp_pvld,
  input  logic [IN_W-1:0]       inp_data,
  input  logic                  inp_last,
  output logic                  inp_prdy,
  output logic                  out_pvld,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_mask,
  output logic                  out_last,
  input  logic                  out_prdy
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);

  logic [CW-1:0]    seg_cnt_q, seg_cnt_d;
  logic [RATIO-1:0] stg_mask_q, stg_mask_d;
  logic [RATIO-1:0] out_mask_q, out_mask_d;
  logic             out_pvld_q, out_pvld_d;
  logic             out_last_q, out_last_d;
  logic [IN_W-1:0]  stg_q [RATIO-1];
  logic [OUT_W-1:0] out_data_q, word_d;
  logic [RATIO-1:0] seg_onehot;
  logic             inp_acc, out_acc, closing;

  assign inp_prdy   = !out_pvld_q | out_prdy;
  assign inp_acc    = inp_pvld & inp_prdy;
  assign out_acc    = out_pvld_q & out_prdy;
  assign closing    = inp_acc & ((seg_cnt_q == CW'(RATIO - 1)) | inp_last);
  assign seg_onehot = RATIO'(1) << seg_cnt_q;

  assign out_pvld = out_pvld_q;
  assign out_data = out_data_q;
  assign out_mask = out_mask_q;
  assign out_last = out_last_q;

  // Top segment has no staging register: it is only ever filled by the closing beat itself.
  always_comb begin
    word_d = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (CW'(k) == seg_cnt_q)
        word_d[k*IN_W +: IN_W] = inp_data;
`ifdef SDP_Y_DMAUNPACK_ZERO_FILL_EN
      else if (CW'(k) < seg_cnt_q)
        word_d[k*IN_W +: IN_W] = stg_q[k];
`else
      else
        word_d[k*IN_W +: IN_W] = stg_q[k];
`endif
    end
    if (seg_cnt_q == CW'(RATIO - 1))
      word_d[(RATIO-1)*IN_W +: IN_W] = inp_data;
  end

  always_comb begin
    seg_cnt_d  = seg_cnt_q;
    stg_mask_d = stg_mask_q;
    out_pvld_d = out_pvld_q;
    out_mask_d = out_mask_q;
    out_last_d = out_last_q;
    if (closing) begin
      seg_cnt_d  = '0;
      stg_mask_d = '0;
      out_pvld_d = 1'b1;
      out_mask_d = stg_mask_q | seg_onehot;
      out_last_d = inp_last;
    end else begin
      if (inp_acc) begin
        seg_cnt_d  = seg_cnt_q + CW'(1);
        stg_mask_d = stg_mask_q | seg_onehot;
      end
      if (out_acc)
        out_pvld_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      seg_cnt_q  <= '0;
      stg_mask_q <= '0;
      out_pvld_q <= 1'b0;
      out_mask_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      seg_cnt_q  <= seg_cnt_d;
      stg_mask_q <= stg_mask_d;
      out_pvld_q <= out_pvld_d;
      out_mask_q <= out_mask_d;
      out_last_q <= out_last_d;
    end
  end

  // Payload registers are qualified by the mask/valid state, so they need no reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (closing)
      out_data_q <= word_d;
    if (inp_acc && !closing) begin
      for (int k = 0; k < RATIO - 1; k++)
        if (CW'(k) == seg_cnt_q)
          stg_q[k] <= inp_data;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_sdp_core_y_dmaunpack_rx.sv
// Bench for the Y-path DMA unpacker: directed cases plus random traffic against a beat-queue reference model.
module tb_nv_nvdla_sdp_core_y_dmaunpack_rx;

  localparam int IN_W  = 64;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic             clk = 1'b0;
  logic             rst;
  logic             inp_pvld, inp_last, inp_prdy;
  logic [IN_W-1:0]  inp_data;
  logic             out_pvld, out_last, out_prdy;
  logic [OUT_W-1:0] out_data;
  logic [RATIO-1:0] out_mask;

  always #5 clk = ~clk;

  nv_nvdla_sdp_core_y_dmaunpack_rx #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .inp_pvld(inp_pvld),
    .inp_data(inp_data),
    .inp_last(inp_last),
    .inp_prdy(inp_prdy),
    .out_pvld(out_pvld),
    .out_data(out_data),
    .out_mask(out_mask),
    .out_last(out_last),
    .out_prdy(out_prdy)
  );

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [RATIO-1:0] mask;
    logic             last;
  } word_t;

  word_t           exp_q[$];
  logic [IN_W-1:0] beats[$];
  int              compared   = 0;
  int              mismatched = 0;

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] seg_bits(input logic [RATIO-1:0] m);
    logic [OUT_W-1:0] r;
    for (int k = 0; k < RATIO; k++) r[k*IN_W +: IN_W] = {IN_W{m[k]}};
    return r;
  endfunction

  task automatic check_outputs(input logic r);
    logic ev;
    ev = (exp_q.size() != 0);
    chk("out_pvld", {255'd0, out_pvld}, {255'd0, ev});
    chk("inp_prdy", {255'd0, inp_prdy}, {255'd0, (!ev | r)});
    if (ev) begin
      chk("out_mask", {252'd0, out_mask}, {252'd0, exp_q[0].mask});
      chk("out_last", {255'd0, out_last}, {255'd0, exp_q[0].last});
`ifdef SDP_Y_DMAUNPACK_ZERO_FILL_EN
      chk("out_data", out_data, exp_q[0].data);
`else
      chk("out_data", out_data & seg_bits(exp_q[0].mask), exp_q[0].data);
`endif
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the reference model.
  task automatic step(input logic v, input logic [IN_W-1:0] d, input logic l, input logic r);
    logic  ev, acc_in, acc_out;
    word_t w, dropped;
    inp_pvld = v; inp_data = d; inp_last = l; out_prdy = r;
    @(negedge clk);
    check_outputs(r);
    ev      = (exp_q.size() != 0);
    acc_in  = v & (!ev | r);
    acc_out = ev & r;
    @(posedge clk); #1;
    if (acc_out) dropped = exp_q.pop_front();
    if (acc_in) begin
      beats.push_back(d);
      if (l || beats.size() == RATIO) begin
        w.data = '0;
        for (int k = 0; k < beats.size(); k++) w.data[k*IN_W +: IN_W] = beats[k];
        w.mask = RATIO'((1 << beats.size()) - 1);
        w.last = l;
        exp_q.push_back(w);
        beats.delete();
      end
    end
  endtask

  task automatic do_reset();
    inp_pvld = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_out_pvld", {255'd0, out_pvld}, '0);
    chk("rst_out_mask", {252'd0, out_mask}, '0);
    chk("rst_out_last", {255'd0, out_last}, '0);
    exp_q.delete();
    beats.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [IN_W-1:0] c0;
    logic [OUT_W-1:0] a_word;
    rst = 1'b1; inp_pvld = 1'b0; inp_data = '0; inp_last = 1'b0; out_prdy = 1'b0;
    #12;
    chk("reset_out_pvld", {255'd0, out_pvld}, '0);
    chk("reset_out_mask", {252'd0, out_mask}, '0);
    chk("reset_out_last", {255'd0, out_last}, '0);
    chk("reset_inp_prdy", {255'd0, inp_prdy}, {255'd0, 1'b1});
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Full word A0..A3
    for (int i = 0; i < 4; i++) step(1'b1, 64'hA0 + 64'(i), 1'b0, 1'b1);
    a_word = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    chk("A_data", out_data, a_word);
    chk("A_mask", {252'd0, out_mask}, {252'd0, 4'hF});
    chk("A_last", {255'd0, out_last}, '0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Partial word B0,B1 closed by inp_last
    step(1'b1, 64'hB0, 1'b0, 1'b1);
    step(1'b1, 64'hB1, 1'b1, 1'b1);
    chk("B_mask", {252'd0, out_mask}, {252'd0, 4'h3});
    chk("B_last", {255'd0, out_last}, {255'd0, 1'b1});
    chk("B_low", {128'd0, out_data[127:0]}, {128'd0, 64'hB1, 64'hB0});
`ifdef SDP_Y_DMAUNPACK_ZERO_FILL_EN
    chk("B_zero_fill", {128'd0, out_data[255:128]}, '0);
`endif

    // Eight back-to-back beats with the sink always ready
    for (int i = 0; i < 8; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);

    // Held word under 5 cycles of backpressure, then release
    for (int i = 0; i < 4; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // inp_last on the very first beat
    c0 = {$urandom, $urandom};
    step(1'b1, c0, 1'b1, 1'b1);
    chk("C_low", {192'd0, out_data[63:0]}, {192'd0, c0});
    chk("C_mask", {252'd0, out_mask}, {252'd0, 4'h1});
    step(1'b0, '0, 1'b0, 1'b1);

    // Reset while a word is pending
    for (int i = 0; i < 4; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    do_reset();

    // Reset with two staged beats, then a clean full word
    step(1'b1, 64'hDEAD_0000, 1'b0, 1'b1);
    step(1'b1, 64'hDEAD_0001, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 64'hE0 + 64'(i), 1'b0, 1'b1);
    chk("E_data", out_data, {64'hE3, 64'hE2, 64'hE1, 64'hE0});
    chk("E_mask", {252'd0, out_mask}, {252'd0, 4'hF});
    step(1'b0, '0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), {$urandom, $urandom},
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) < 7));
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
